bits_needed_tracker: RTL and testbench
======================================

Name: bits_needed_tracker

Overview:
- Sequential successor of the combinational bits-needed logic in the VVC arithmetic decoder.
- Owns the signed m_bitsNeeded register and runs the initial bitstream load.
- Accepts one decode operation per cycle. Each operation is a regular-bin renorm, or a multi-bin bypass of up to MAX_SHIFT bits.
- Fetches as many bytes as the operation requires through a valid/ready byte stream, stalling the decode engine while it fetches.

Parameters:
- MAX_SHIFT, 16: maximum bits consumed by one bypass operation (1..16).
- SHIFT_WIDTH, 5: width of op_shift and load_shift; must satisfy 2^SHIFT_WIDTH > max(MAX_SHIFT, 8*(INIT_BYTES-1)).
- BN_WIDTH, 6: signed width of the bits-needed register; must hold -8..MAX_SHIFT-1.
- INIT_BYTES, 2: bytes loaded at start before normal operation.
- REG_MAX_SHIFT, 7: maximum legal shift for a regular (non-bypass) operation.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  single-cycle pulse: begin slice/init load
- op_valid  in  1  decode operation present
- op_ready  out  1  tracker can accept an operation
- op_bypass  in  1  1 = bypass operation, 0 = regular
- op_renorm  in  1  regular only: renormalisation happened (0 means MPS without renorm, shift ignored)
- op_shift  in  SHIFT_WIDTH  bits consumed (bypass: numBits; regular: renorm count)
- byte_valid  in  1  bitstream byte available
- byte_ready  out  1  tracker consumes byte this cycle
- byte_data  in  8  bitstream byte
- load_valid  out  1  datapath must add load_byte << load_shift into m_value this cycle
- load_init  out  1  current load is an init byte
- load_byte  out  8  byte to merge
- load_shift  out  SHIFT_WIDTH  left shift for load_byte
- bits_needed  out  BN_WIDTH  current m_bitsNeeded (signed)
- busy  out  1  state is INIT or FETCH
- err_shift  out  1  sticky: illegal shift seen

Behaviour:
- Reset values: state IDLE, bits_needed = -8, op_ready = 0, byte_ready = 0, load_valid = 0, load_init = 0, load_byte = 0, load_shift = 0, busy = 0, err_shift = 0.
- Reset has priority over everything. Reset during INIT or FETCH abandons the fetch; no further byte_ready is issued.
- States:
  - IDLE: waiting for start.
  - INIT: loading init bytes; a byte index counter runs 0..INIT_BYTES-1.
  - ACTIVE: op_ready = 1.
  - FETCH: byte_ready = 1, op_ready = 0.
- start in any state (except during rst) → INIT with index = 0 and bits_needed = -8; this clears an in-progress fetch. start wins over a simultaneous op handshake, and that op is not accepted.
- INIT:
  - byte_ready = 1.
  - On byte_valid: load_valid = 1, load_init = 1, load_shift = 8*(INIT_BYTES-1-index), index++.
  - After the last byte → ACTIVE, bits_needed stays -8.
- ACTIVE, op handshake:
  - eff_shift = op_bypass ? op_shift : (op_renorm ? op_shift : 0).
  - sum = bits_needed + eff_shift, computed in BN_WIDTH+1 bits signed; bits_needed <= sum.
  - sum < 0: remain ACTIVE, so back-to-back ops are accepted every cycle.
  - sum >= 0: → FETCH next cycle.
- FETCH, on byte_valid:
  - Outputs, combinational in the same cycle: load_valid = 1, load_init = 0, load_byte = byte_data, load_shift = bits_needed[SHIFT_WIDTH-1:0] (value 0..MAX_SHIFT-1).
  - Register update: bits_needed <= bits_needed - 8.
  - If the new value is < 0 → ACTIVE, otherwise stay in FETCH for another byte.
  - Number of bytes fetched = floor(sum/8) + 1.
  - byte_valid low: hold state and outputs indefinitely (stall). No timeout.
- load_valid is never asserted outside a byte handshake. load_byte and load_shift are 0 when load_valid = 0.
- Shift legality:
  - Bypass op_shift > MAX_SHIFT or regular op_shift > REG_MAX_SHIFT (with op_renorm = 1) sets err_shift, which is sticky until rst or start.
  - The operation is still executed, with op_shift clamped to the legal maximum.
- Bypass op_shift = 0 is legal: a no-op handshake, bits_needed unchanged.
- op_valid while not op_ready: the op is held by the producer and is not sampled.
- busy = state is INIT or FETCH.

Test Plan:
- Init: start with INIT_BYTES = 2, bytes 0xA5, 0x3C presented back to back → load_shift 8 then 0, both with load_init = 1; ACTIVE 2 cycles after the first byte_valid; bits_needed = -8.
- Regular ops without fetch: bits_needed = -8, ops (renorm, shift 3) then (renorm = 0, shift 5) then (renorm, shift 2) on consecutive cycles → bits_needed -5, -5, -3; op_ready stays 1; no byte_ready.
- Single fetch: bits_needed = -3, regular renorm shift 6 → sum 3, FETCH; byte 0x7F → load_shift = 3; bits_needed = -5; back in ACTIVE.
- Multi-byte bypass: bits_needed = -1, bypass shift 16 → sum 15; two byte handshakes with load_shift 15 then 7; final bits_needed = -1.
- Stall: in FETCH with byte_valid low for 5 cycles → op_ready = 0, busy = 1, bits_needed constant, load_valid = 0 throughout.
- Errors and priority: regular shift 9 → err_shift = 1, shift clamped to 7; start asserted mid-FETCH → INIT with bits_needed = -8 and err_shift cleared; rst mid-INIT → every output at its reset value next cycle.

Source files
------------

// File: rtl/bits_needed_tracker.sv
// Tracks the arithmetic decoder's signed bits-needed count, runs the initial
// bitstream load, and fetches bitstream bytes whenever decode operations exhaust it.
module bits_needed_tracker #(
  parameter int MAX_SHIFT     = 16,
  parameter int SHIFT_WIDTH   = 5,
  parameter int BN_WIDTH      = 6,
  parameter int INIT_BYTES    = 2,
  parameter int REG_MAX_SHIFT = 7
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       op_valid,
  output logic                       op_ready,
  input  logic                       op_bypass,
  input  logic                       op_renorm,
  input  logic [SHIFT_WIDTH-1:0]     op_shift,
  input  logic                       byte_valid,
  output logic                       byte_ready,
  input  logic [7:0]                 byte_data,
  output logic                       load_valid,
  output logic                       load_init,
  output logic [7:0]                 load_byte,
  output logic [SHIFT_WIDTH-1:0]     load_shift,
  output logic signed [BN_WIDTH-1:0] bits_needed,
  output logic                       busy,
  output logic                       err_shift,
  output logic [1:0]                 dbg_state
);

  // Handshakes: a transfer happens on a cycle where valid and ready are both
  // high at the clock edge; ready never waits on valid, and start withdraws
  // every ready so nothing is transferred in the cycle that restarts the slice.

  typedef enum logic [1:0] {ST_IDLE, ST_INIT, ST_ACTIVE, ST_FETCH} state_t;

  localparam int IDX_W = (INIT_BYTES > 1) ? $clog2(INIT_BYTES) : 1;
  localparam logic [IDX_W-1:0]       IDX_LAST  = IDX_W'(INIT_BYTES - 1);
  localparam logic [SHIFT_WIDTH-1:0] MAX_S     = SHIFT_WIDTH'(MAX_SHIFT);
  localparam logic [SHIFT_WIDTH-1:0] REG_MAX_S = SHIFT_WIDTH'(REG_MAX_SHIFT);
  localparam logic [BN_WIDTH-1:0]    BN_RESET  = BN_WIDTH'(-8);

  state_t                   state_q, state_d;
  logic [BN_WIDTH-1:0]      bn_q, bn_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic                     err_q, err_d;
  logic [SHIFT_WIDTH-1:0]   eff_shift;
  logic                     shift_illegal;
  logic [BN_WIDTH:0]        sum;
  logic [BN_WIDTH-1:0]      bn_minus8;
  logic [SHIFT_WIDTH-1:0]   init_shift;
  logic                     op_fire, byte_fire;

  // Oversized shifts are clamped so the count stays within its legal range.
  always_comb begin
    eff_shift     = '0;
    shift_illegal = 1'b0;
    if (op_bypass) begin
      if (op_shift > MAX_S) begin
        eff_shift     = MAX_S;
        shift_illegal = 1'b1;
      end else begin
        eff_shift = op_shift;
      end
    end else if (op_renorm) begin
      if (op_shift > REG_MAX_S) begin
        eff_shift     = REG_MAX_S;
        shift_illegal = 1'b1;
      end else begin
        eff_shift = op_shift;
      end
    end
  end

  assign sum        = {bn_q[BN_WIDTH-1], bn_q} + {{(BN_WIDTH+1-SHIFT_WIDTH){1'b0}}, eff_shift};
  assign bn_minus8  = bn_q - BN_WIDTH'(8);
  assign init_shift = SHIFT_WIDTH'(8 * (INIT_BYTES - 1 - int'(idx_q)));

  assign op_ready   = (state_q == ST_ACTIVE) && !start;
  assign byte_ready = ((state_q == ST_INIT) || (state_q == ST_FETCH)) && !start;
  assign op_fire    = op_ready && op_valid;
  assign byte_fire  = byte_ready && byte_valid;

  always_comb begin
    load_valid = byte_fire;
    load_init  = 1'b0;
    load_byte  = 8'h00;
    load_shift = '0;
    if (byte_fire) begin
      load_byte = byte_data;
      if (state_q == ST_INIT) begin
        load_init  = 1'b1;
        load_shift = init_shift;
      end else begin
        load_shift = bn_q[SHIFT_WIDTH-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    bn_d    = bn_q;
    idx_d   = idx_q;
    err_d   = err_q;
    case (state_q)
      ST_INIT: begin
        if (byte_fire) begin
          idx_d = idx_q + IDX_W'(1);
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = ST_ACTIVE;
          end
        end
      end
      ST_ACTIVE: begin
        if (op_fire) begin
          bn_d  = sum[BN_WIDTH-1:0];
          err_d = err_q | shift_illegal;
          if (!sum[BN_WIDTH]) state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (byte_fire) begin
          bn_d = bn_minus8;
          if (bn_minus8[BN_WIDTH-1]) state_d = ST_ACTIVE;
        end
      end
      default: ;
    endcase
    // A new slice discards whatever was in flight, including the sticky error.
    if (start) begin
      state_d = ST_INIT;
      idx_d   = '0;
      bn_d    = BN_RESET;
      err_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      bn_q    <= BN_RESET;
      idx_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bn_q    <= bn_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
    end
  end

  assign bits_needed = bn_q;
  assign busy        = (state_q == ST_INIT) || (state_q == ST_FETCH);
  assign err_shift   = err_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_bits_needed_tracker.sv
// Directed bench for bits_needed_tracker: init load, regular and bypass ops,
// single/multi-byte fetches, stalls, shift clamping, start and reset priority.
module tb_bits_needed_tracker;

  logic              clk = 1'b0;
  logic              rst, start, op_valid, op_bypass, op_renorm, byte_valid;
  logic [4:0]        op_shift;
  logic [7:0]        byte_data;
  logic              op_ready, byte_ready, load_valid, load_init, busy, err_shift;
  logic [7:0]        load_byte;
  logic [4:0]        load_shift;
  logic signed [5:0] bits_needed;
  logic [1:0]        dbg_state;
  int                total = 0;
  int                bad = 0;

  bits_needed_tracker dut (
    .clk(clk), .rst(rst), .start(start),
    .op_valid(op_valid), .op_ready(op_ready), .op_bypass(op_bypass),
    .op_renorm(op_renorm), .op_shift(op_shift),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .byte_data(byte_data),
    .load_valid(load_valid), .load_init(load_init), .load_byte(load_byte),
    .load_shift(load_shift), .bits_needed(bits_needed), .busy(busy),
    .err_shift(err_shift), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Inputs change 1ns after the rising edge; outputs are checked 1ns later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic v, input logic byp, input logic ren, input logic [4:0] sh);
    op_valid = v; op_bypass = byp; op_renorm = ren; op_shift = sh;
  endtask

  task automatic go_active();
    start = 1'b1; cyc(); start = 1'b0;
    byte_valid = 1'b1; byte_data = 8'h00; cyc(); cyc();
    byte_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    set_op(1'b0, 1'b0, 1'b0, 5'd0);
    cyc(); cyc(); rst = 1'b0; #1;
    total++; if (op_ready !== 1'b0) begin bad++; $display("FAIL reset_op_ready got=%b exp=0", op_ready); end
    total++; if (byte_ready !== 1'b0) begin bad++; $display("FAIL reset_byte_ready got=%b exp=0", byte_ready); end
    total++; if (load_valid !== 1'b0) begin bad++; $display("FAIL reset_load_valid got=%b exp=0", load_valid); end
    total++; if (bits_needed !== -6'sd8) begin bad++; $display("FAIL reset_bits_needed got=%0d exp=-8", bits_needed); end
    total++; if (busy !== 1'b0 || err_shift !== 1'b0) begin bad++; $display("FAIL reset_busy_err got=%b%b exp=00", busy, err_shift); end
  endtask

  task automatic test_init();
    start = 1'b1; cyc(); start = 1'b0;
    byte_valid = 1'b1; byte_data = 8'hA5; #1;
    total++; if (load_valid !== 1'b1 || load_init !== 1'b1) begin bad++; $display("FAIL init0_load got=%b%b exp=11", load_valid, load_init); end
    total++; if (load_shift !== 5'd8 || load_byte !== 8'hA5) begin bad++; $display("FAIL init0_shift_byte got=%0d/%h exp=8/a5", load_shift, load_byte); end
    total++; if (busy !== 1'b1 || op_ready !== 1'b0) begin bad++; $display("FAIL init0_busy got=%b op_ready=%b exp=1/0", busy, op_ready); end
    cyc(); byte_data = 8'h3C; #1;
    total++; if (load_shift !== 5'd0 || load_init !== 1'b1 || load_byte !== 8'h3C) begin bad++; $display("FAIL init1_load got=%0d/%b/%h exp=0/1/3c", load_shift, load_init, load_byte); end
    cyc(); byte_valid = 1'b0; #1;
    total++; if (op_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL init_active got=%b busy=%b exp=1/0", op_ready, busy); end
    total++; if (bits_needed !== -6'sd8) begin bad++; $display("FAIL init_bits_needed got=%0d exp=-8", bits_needed); end
  endtask

  task automatic test_regular_ops();
    set_op(1'b1, 1'b0, 1'b1, 5'd3); #1;
    total++; if (op_ready !== 1'b1) begin bad++; $display("FAIL reg_op_ready0 got=%b exp=1", op_ready); end
    cyc(); set_op(1'b1, 1'b0, 1'b0, 5'd5); #1;
    total++; if (bits_needed !== -6'sd5 || op_ready !== 1'b1) begin bad++; $display("FAIL reg_op1 got=%0d op_ready=%b exp=-5/1", bits_needed, op_ready); end
    cyc(); set_op(1'b1, 1'b0, 1'b1, 5'd2); #1;
    total++; if (bits_needed !== -6'sd5 || byte_ready !== 1'b0) begin bad++; $display("FAIL reg_op2 got=%0d byte_ready=%b exp=-5/0", bits_needed, byte_ready); end
    cyc(); set_op(1'b0, 1'b0, 1'b0, 5'd0); #1;
    total++; if (bits_needed !== -6'sd3 || op_ready !== 1'b1 || byte_ready !== 1'b0) begin bad++; $display("FAIL reg_op3 got=%0d op_ready=%b byte_ready=%b exp=-3/1/0", bits_needed, op_ready, byte_ready); end
  endtask

  task automatic test_single_fetch();
    set_op(1'b1, 1'b0, 1'b1, 5'd6);
    cyc(); set_op(1'b0, 1'b0, 1'b0, 5'd0); #1;
    total++; if (bits_needed !== 6'sd3 || op_ready !== 1'b0 || byte_ready !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL fetch1_enter got=%0d op_ready=%b byte_ready=%b busy=%b exp=3/0/1/1", bits_needed, op_ready, byte_ready, busy); end
    byte_valid = 1'b1; byte_data = 8'h7F; #1;
    total++; if (load_valid !== 1'b1 || load_init !== 1'b0 || load_shift !== 5'd3 || load_byte !== 8'h7F) begin bad++; $display("FAIL fetch1_load got=%b/%b/%0d/%h exp=1/0/3/7f", load_valid, load_init, load_shift, load_byte); end
    cyc(); byte_valid = 1'b0; #1;
    total++; if (bits_needed !== -6'sd5 || op_ready !== 1'b1 || load_valid !== 1'b0) begin bad++; $display("FAIL fetch1_done got=%0d op_ready=%b load_valid=%b exp=-5/1/0", bits_needed, op_ready, load_valid); end
  endtask

  task automatic test_multi_bypass();
    set_op(1'b1, 1'b0, 1'b1, 5'd4);
    cyc(); set_op(1'b1, 1'b1, 1'b0, 5'd16); #1;
    total++; if (bits_needed !== -6'sd1 || op_ready !== 1'b1) begin bad++; $display("FAIL byp_pre got=%0d op_ready=%b exp=-1/1", bits_needed, op_ready); end
    cyc(); set_op(1'b0, 1'b0, 1'b0, 5'd0);
    byte_valid = 1'b1; byte_data = 8'h11; #1;
    total++; if (bits_needed !== 6'sd15 || load_shift !== 5'd15 || load_byte !== 8'h11) begin bad++; $display("FAIL byp_byte0 got=%0d/%0d/%h exp=15/15/11", bits_needed, load_shift, load_byte); end
    cyc(); byte_data = 8'h22; #1;
    total++; if (bits_needed !== 6'sd7 || load_shift !== 5'd7 || busy !== 1'b1) begin bad++; $display("FAIL byp_byte1 got=%0d/%0d busy=%b exp=7/7/1", bits_needed, load_shift, busy); end
    cyc(); byte_valid = 1'b0; #1;
    total++; if (bits_needed !== -6'sd1 || op_ready !== 1'b1) begin bad++; $display("FAIL byp_done got=%0d op_ready=%b exp=-1/1", bits_needed, op_ready); end
  endtask

  task automatic test_stall();
    set_op(1'b1, 1'b1, 1'b0, 5'd8);
    cyc(); set_op(1'b0, 1'b0, 1'b0, 5'd0);
    for (int i = 0; i < 5; i++) begin
      #1;
      total++; if (op_ready !== 1'b0 || busy !== 1'b1 || bits_needed !== 6'sd7 || load_valid !== 1'b0 || load_shift !== 5'd0) begin bad++; $display("FAIL stall_%0d op_ready=%b busy=%b bn=%0d lv=%b ls=%0d exp=0/1/7/0/0", i, op_ready, busy, bits_needed, load_valid, load_shift); end
      cyc();
    end
    byte_valid = 1'b1; byte_data = 8'h5A; #1;
    total++; if (load_valid !== 1'b1 || load_shift !== 5'd7) begin bad++; $display("FAIL stall_release got=%b/%0d exp=1/7", load_valid, load_shift); end
    cyc(); byte_valid = 1'b0; #1;
    total++; if (bits_needed !== -6'sd1 || op_ready !== 1'b1) begin bad++; $display("FAIL stall_done got=%0d op_ready=%b exp=-1/1", bits_needed, op_ready); end
  endtask

  task automatic test_bypass_zero();
    set_op(1'b1, 1'b1, 1'b0, 5'd0);
    cyc(); set_op(1'b0, 1'b0, 1'b0, 5'd0); #1;
    total++; if (bits_needed !== -6'sd1 || op_ready !== 1'b1 || busy !== 1'b0 || err_shift !== 1'b0) begin bad++; $display("FAIL byp_zero got=%0d op_ready=%b busy=%b err=%b exp=-1/1/0/0", bits_needed, op_ready, busy, err_shift); end
  endtask

  task automatic test_errors();
    set_op(1'b1, 1'b0, 1'b1, 5'd9);
    cyc(); set_op(1'b0, 1'b0, 1'b0, 5'd0); #1;
    total++; if (err_shift !== 1'b1 || bits_needed !== 6'sd6 || busy !== 1'b1) begin bad++; $display("FAIL reg_clamp got=err%b bn=%0d busy=%b exp=1/6/1", err_shift, bits_needed, busy); end
    start = 1'b1; byte_valid = 1'b1; byte_data = 8'hEE; #1;
    total++; if (byte_ready !== 1'b0 || load_valid !== 1'b0) begin bad++; $display("FAIL start_gate got=%b/%b exp=0/0", byte_ready, load_valid); end
    cyc(); start = 1'b0; byte_valid = 1'b0; #1;
    total++; if (bits_needed !== -6'sd8 || err_shift !== 1'b0 || busy !== 1'b1 || byte_ready !== 1'b1 || op_ready !== 1'b0) begin bad++; $display("FAIL start_mid_fetch bn=%0d err=%b busy=%b br=%b or=%b exp=-8/0/1/1/0", bits_needed, err_shift, busy, byte_ready, op_ready); end
    byte_valid = 1'b1; cyc(); cyc(); byte_valid = 1'b0;
    set_op(1'b1, 1'b1, 1'b0, 5'd20);
    cyc(); set_op(1'b0, 1'b0, 1'b0, 5'd0);
    byte_valid = 1'b1; byte_data = 8'h01; #1;
    total++; if (err_shift !== 1'b1 || bits_needed !== 6'sd8 || load_shift !== 5'd8) begin bad++; $display("FAIL byp_clamp got=err%b bn=%0d ls=%0d exp=1/8/8", err_shift, bits_needed, load_shift); end
    cyc(); #1;
    total++; if (bits_needed !== 6'sd0 || load_shift !== 5'd0 || busy !== 1'b1 || load_valid !== 1'b1) begin bad++; $display("FAIL byp_zero_edge got=bn%0d ls=%0d busy=%b lv=%b exp=0/0/1/1", bits_needed, load_shift, busy, load_valid); end
    cyc(); byte_valid = 1'b0; #1;
    total++; if (bits_needed !== -6'sd8 || op_ready !== 1'b1 || err_shift !== 1'b1) begin bad++; $display("FAIL byp_clamp_done got=%0d op_ready=%b err=%b exp=-8/1/1", bits_needed, op_ready, err_shift); end
    start = 1'b1; cyc(); start = 1'b0;
    byte_valid = 1'b1; byte_data = 8'h55; cyc();
    rst = 1'b1; byte_valid = 1'b0; cyc(); rst = 1'b0; byte_valid = 1'b1; #1;
    total++; if (op_ready !== 1'b0 || byte_ready !== 1'b0 || load_valid !== 1'b0 || load_init !== 1'b0) begin bad++; $display("FAIL rst_mid_init_hs got=%b%b%b%b exp=0000", op_ready, byte_ready, load_valid, load_init); end
    total++; if (load_byte !== 8'h00 || load_shift !== 5'd0 || bits_needed !== -6'sd8 || busy !== 1'b0 || err_shift !== 1'b0) begin bad++; $display("FAIL rst_mid_init_vals got=%h/%0d/%0d/%b/%b exp=00/0/-8/0/0", load_byte, load_shift, bits_needed, busy, err_shift); end
    byte_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_init();
    test_regular_ops();
    test_single_fetch();
    test_multi_bypass();
    test_stall();
    test_bypass_zero();
    test_errors();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
